// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
// Holds the MD operation encodings, the controller state type and small
// decode helpers. The instruction decoder imports the same package so
// the op encoding stays consistent.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NOP6  = 3'd6,
    MD_NOP7  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Multi-cycle ops: MULT, MULTU, DIV, DIVU.
  function automatic logic is_long_op(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_result.sv
// Combinational result datapath for the multiply/divide unit.
// Ports:
//   op       latched MD operation
//   a, b     latched operands (rs, rt)
//   result   {hi, lo} result: product, or {remainder, quotient}
//   div_zero divide op with b == 0; caller must not commit result
module md_result
  import md_unit_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_zero
);

  logic               b_zero;
  logic               s_ovf;
  logic signed [63:0] a_sx;
  logic signed [63:0] b_sx;
  logic signed [31:0] s_div;
  logic signed [31:0] s_quo;
  logic signed [31:0] s_rem;
  logic        [31:0] u_div;
  logic        [31:0] u_quo;
  logic        [31:0] u_rem;

  always_comb begin
    b_zero = (b == '0);
    // Most-negative / -1 overflows a 32-bit signed divide; it is handled
    // by a dedicated result and the divider sees a harmless divisor.
    s_ovf  = (a == 32'h8000_0000) && (b == '1);
    a_sx   = {{32{a[31]}}, a};
    b_sx   = {{32{b[31]}}, b};
    s_div  = (b_zero || s_ovf) ? 32'sd1 : $signed(b);
    u_div  = b_zero ? 32'd1 : b;
    s_quo  = $signed(a) / s_div;
    s_rem  = $signed(a) % s_div;
    u_quo  = a / u_div;
    u_rem  = a % u_div;

    result   = '0;
    div_zero = is_div_op(op) && b_zero;

    case (op)
      MD_MULT:  result = a_sx * b_sx;
      MD_MULTU: result = {32'd0, a} * {32'd0, b};
      MD_DIV:   result = s_ovf ? {32'd0, 32'h8000_0000} : {s_rem, s_quo};
      MD_DIVU:  result = {u_rem, u_quo};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit (EX stage) holding the HI/LO registers.
// MULT/MULTU/DIV/DIVU run with fixed latency; MTHI/MTLO complete in one edge.
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   start    issue strobe, sampled at posedge
//   md_op    0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   rs_data  operand A / MTHI, MTLO source
//   rt_data  operand B
//   busy     operation in flight (registered)
//   hi, lo   HI/LO architectural registers
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  md_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  md_op_e      op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_d, lo_d;
  md_op_e      op_in;
  logic [63:0] result;
  logic        div_zero;

  assign op_in = md_op_e'(md_op);

  md_result u_result (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .result   (result),
    .div_zero (div_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi      <= hi_d;
      lo      <= lo_d;
      busy    <= (state_d == ST_RUN);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi;
    lo_d    = lo;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_long_op(op_in)) begin
            op_d    = op_in;
            a_d     = rs_data;
            b_d     = rt_data;
            cnt_d   = is_div_op(op_in) ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
            state_d = ST_RUN;
          end else if (op_in == MD_MTHI) begin
            hi_d = rs_data;
          end else if (op_in == MD_MTLO) begin
            lo_d = rs_data;
          end
        end
      end
      ST_RUN: begin
        // start is ignored here; the hazard unit stalls MD instructions.
        if (cnt_q == '0) begin
          if (!div_zero) begin
            hi_d = result[63:32];
            lo_d = result[31:0];
          end
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd6;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference architectural state
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .md_op   (md_op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  function automatic int exp_cycles(input logic [2:0] op);
    if (op <= 3'd1) return 5;
    if (op <= 3'd3) return 10;
    return 0;
  endfunction

  // Reference model: MIPS HI/LO semantics using 64-bit integer arithmetic.
  task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sp, sa, sb, sq, sr;
    longint unsigned up;
    logic [63:0]     v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin sp = sa * sb; v = sp; m_hi = v[63:32]; m_lo = v[31:0]; end
      3'd1: begin up = longint'(a) * longint'(b); v = up; m_hi = v[63:32]; m_lo = v[31:0]; end
      3'd2: if (b != 0) begin
              sq = sa / sb; sr = sa % sb;
              v = sq; m_lo = v[31:0];
              v = sr; m_hi = v[31:0];
            end
      3'd3: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  // Issue one op and count the cycles busy stays high (bounded).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    @(negedge clk);
    start = 1'b1; md_op = op; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'($urandom_range(0, 7)); rs_data = $urandom; rt_data = $urandom;
    cycles = 0;
    while (busy === 1'b1 && cycles < 40) begin
      cycles++;
      @(posedge clk); #1;
    end
    model_apply(op, a, b);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b hi=%h lo=%h required 0/0/0", busy, hi, lo);
    end
    @(negedge clk); reset = 1'b1;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_directed;
    int c;
    run_op(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, c);
    n_checks++;
    if (c !== 5 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      n_fail++;
      $display("FAIL mult_dir: cyc=%0d hi=%h lo=%h required 5 ffffffff fffffffa", c, hi, lo);
    end
    run_op(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, c);
    n_checks++;
    if (c !== 5 || hi !== 32'h0000_0002 || lo !== 32'hFFFF_FFFA) begin
      n_fail++;
      $display("FAIL multu_dir: cyc=%0d hi=%h lo=%h required 5 00000002 fffffffa", c, hi, lo);
    end
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, c);
    n_checks++;
    if (c !== 10 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      n_fail++;
      $display("FAIL div_dir: cyc=%0d hi=%h lo=%h required 10 ffffffff fffffffd", c, hi, lo);
    end
    run_op(3'd3, 32'd7, 32'd2, c);
    n_checks++;
    if (c !== 10 || hi !== 32'd1 || lo !== 32'd3) begin
      n_fail++;
      $display("FAIL divu_dir: cyc=%0d hi=%h lo=%h required 10 1 3", c, hi, lo);
    end
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, c);
    n_checks++;
    if (c !== 10 || hi !== 32'h0 || lo !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL div_ovf: cyc=%0d hi=%h lo=%h required 10 0 80000000", c, hi, lo);
    end
  endtask

  task automatic test_mthi_mtlo_divzero;
    int c;
    run_op(3'd4, 32'h1234_5678, 32'hDEAD_BEEF, c);
    n_checks++;
    if (c !== 0 || hi !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL mthi: cyc=%0d hi=%h required 0 12345678", c, hi);
    end
    run_op(3'd5, 32'h9ABC_DEF0, 32'h0, c);
    n_checks++;
    if (c !== 0 || lo !== 32'h9ABC_DEF0 || hi !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL mtlo: cyc=%0d hi=%h lo=%h required 0 12345678 9abcdef0", c, hi, lo);
    end
    run_op(3'd2, 32'd100, 32'd0, c);
    n_checks++;
    if (c !== 10 || hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) begin
      n_fail++;
      $display("FAIL div_zero: cyc=%0d hi=%h lo=%h required 10 12345678 9abcdef0", c, hi, lo);
    end
    run_op(3'd3, 32'hFFFF_0000, 32'd0, c);
    n_checks++;
    if (c !== 10 || hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) begin
      n_fail++;
      $display("FAIL divu_zero: cyc=%0d hi=%h lo=%h required 10 12345678 9abcdef0", c, hi, lo);
    end
    run_op(3'd6, 32'h5555_5555, 32'd1, c);
    run_op(3'd7, 32'hAAAA_AAAA, 32'd1, c);
    n_checks++;
    if (c !== 0 || hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) begin
      n_fail++;
      $display("FAIL nop_ops: cyc=%0d hi=%h lo=%h required 0 12345678 9abcdef0", c, hi, lo);
    end
  endtask

  task automatic test_start_while_busy;
    int c;
    logic [31:0] a, b;
    a = 32'h0001_2345; b = 32'hFFFF_FF00;
    @(negedge clk);
    start = 1'b1; md_op = 3'd0; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (busy === 1'b1 && c < 40) begin
      c++;
      if (c == 2) begin
        start = 1'b1; md_op = 3'd5; rs_data = 32'hCAFE_F00D; rt_data = 32'h7;
      end else if (c == 4) begin
        start = 1'b1; md_op = 3'd2; rs_data = 32'd9; rt_data = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    model_apply(3'd0, a, b);
    n_checks++;
    if (c !== 5 || hi !== m_hi || lo !== m_lo) begin
      n_fail++;
      $display("FAIL busy_ignore: cyc=%0d hi=%h lo=%h required 5 %h %h", c, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_reset_abort;
    int c;
    @(negedge clk);
    start = 1'b1; md_op = 3'd2; rs_data = 32'd1000; rt_data = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    while (c < 4) begin @(posedge clk); #1; c++; end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++;
      $display("FAIL async_abort: busy=%b hi=%h lo=%h required 0 0 0", busy, hi, lo);
    end
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++;
      $display("FAIL no_late_update: busy=%b hi=%h lo=%h required 0 0 0", busy, hi, lo);
    end
    run_op(3'd0, 32'd6, 32'hFFFF_FFF9, c);
    n_checks++;
    if (c !== 5 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFD6) begin
      n_fail++;
      $display("FAIL mult_after_reset: cyc=%0d hi=%h lo=%h required 5 ffffffff ffffffd6", c, hi, lo);
    end
  endtask

  task automatic test_random;
    int c;
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: begin a = 32'h8000_0000; b = '1; end
        default: ;
      endcase
      run_op(op, a, b, c);
      n_checks++;
      if (c !== exp_cycles(op) || hi !== m_hi || lo !== m_lo) begin
        n_fail++;
        $display("FAIL random_op%0d: op=%0d a=%h b=%h cyc=%0d hi=%h lo=%h required %0d %h %h",
                 i, op, a, b, c, hi, lo, exp_cycles(op), m_hi, m_lo);
      end
    end
  endtask

  task automatic test_back_to_back;
    int c;
    logic [31:0] a, b;
    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = $urandom;
      @(negedge clk);
      start = 1'b1; md_op = 3'(i % 4); rs_data = a; rt_data = b;
      @(posedge clk); #1;
      c = 0;
      // Keep start asserted with the same op for the whole run; it must be ignored.
      while (busy === 1'b1 && c < 40) begin c++; @(posedge clk); #1; end
      start = 1'b0;
      model_apply(3'(i % 4), a, b);
      n_checks++;
      if (c !== exp_cycles(3'(i % 4)) || hi !== m_hi || lo !== m_lo) begin
        n_fail++;
        $display("FAIL back_to_back%0d: cyc=%0d hi=%h lo=%h required %0d %h %h",
                 i, c, hi, lo, exp_cycles(3'(i % 4)), m_hi, m_lo);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_mthi_mtlo_divzero;
    test_start_while_busy;
    test_reset_abort;
    test_random;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
